// File: rtl/mux_sel_arbiter_if.sv
// Handshake bundle between the two requesters, the downstream ready and the
// 2:1 mux arbiter.
//   req_a, req_b : requester levels (driven by the requester side)
//   ready        : downstream accepts the current transfer this cycle
//   sel          : mux select, 0 = a, 1 = b
//   grant_a/b    : one-hot ownership of the mux path
//   valid        : grant_a | grant_b
// Modports: slave = the arbiter, master = the requester/downstream side.
interface mux_sel_arbiter_if;
    logic req_a;
    logic req_b;
    logic ready;
    logic sel;
    logic grant_a;
    logic grant_b;
    logic valid;

    modport slave (
        input  req_a,
        input  req_b,
        input  ready,
        output sel,
        output grant_a,
        output grant_b,
        output valid
    );

    modport master (
        output req_a,
        output req_b,
        output ready,
        input  sel,
        input  grant_a,
        input  grant_b,
        input  valid
    );
endinterface

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: upstream control stage for the 2:1 mux. Arbitrates between
// requesters a and b, drives the mux select and a one-hot grant, and limits a
// grant to MAX_HOLD accepted transfers while the other side is waiting.
// Ports:
//   clk  : single clock, all state on the rising edge
//   rst  : synchronous, active-high reset
//   bus  : mux_sel_arbiter_if.slave (req_a, req_b, ready in; sel, grant_a,
//          grant_b, valid out, all outputs registered)
// Parameters: MAX_HOLD (1..2**CNT_W-1), CNT_W (hold counter width).
// Build option: ARB_FIXED_PRIO_EN -- when defined every tie goes to a;
// when undefined (default) ties go round robin to the side != last.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; arbitrate every cycle, sel keeps its previous value
// GNT_A | a owns the mux path (sel=0), hold_cnt counts a's transfers
// GNT_B | b owns the mux path (sel=1), hold_cnt counts b's transfers
module mux_sel_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    mux_sel_arbiter_if.slave  bus
);

    generate
        if (MAX_HOLD < 1 || MAX_HOLD > (2**CNT_W) - 1) begin : g_bad_max_hold
            $error("mux_sel_arbiter: MAX_HOLD must be in 1..2**CNT_W-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t            state, state_nxt;
    state_t            arb_pick;
    state_t            tie_pick;
    logic [CNT_W-1:0]  hold_cnt, hold_cnt_nxt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              last, last_nxt;      // 0 = a was granted last, 1 = b
    logic              xfer;
    logic              sel_q, sel_nxt;
    logic              grant_a_q, grant_b_q, valid_q;

    assign bus.sel     = sel_q;
    assign bus.grant_a = grant_a_q;
    assign bus.grant_b = grant_b_q;
    assign bus.valid   = valid_q;

`ifdef ARB_FIXED_PRIO_EN
    assign tie_pick = GNT_A;
`else
    assign tie_pick = last ? GNT_A : GNT_B;
`endif

    assign xfer    = valid_q && bus.ready;
    // Saturating increment; the counter is cleared at MAX_HOLD so the
    // saturation only guards against an out-of-range configuration.
    assign cnt_inc = (hold_cnt == {CNT_W{1'b1}}) ? hold_cnt : hold_cnt + CNT_W'(1);

    always_comb begin
        arb_pick = IDLE;
        case ({bus.req_a, bus.req_b})
            2'b10:   arb_pick = GNT_A;
            2'b01:   arb_pick = GNT_B;
            2'b11:   arb_pick = tie_pick;
            default: arb_pick = IDLE;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        last_nxt     = last;
        sel_nxt      = sel_q;

        case (state)
            IDLE: begin
                state_nxt = arb_pick;
            end
            GNT_A: begin
                if (!bus.req_a) begin
                    state_nxt = arb_pick;
                end else if (xfer) begin
                    if (cnt_inc == HOLD_LIM) begin
                        // Hold limit reached: hand over only if b is waiting.
                        hold_cnt_nxt = '0;
                        if (bus.req_b) state_nxt = GNT_B;
                    end else begin
                        hold_cnt_nxt = cnt_inc;
                    end
                end
            end
            GNT_B: begin
                if (!bus.req_b) begin
                    state_nxt = arb_pick;
                end else if (xfer) begin
                    if (cnt_inc == HOLD_LIM) begin
                        hold_cnt_nxt = '0;
                        if (bus.req_a) state_nxt = GNT_A;
                    end else begin
                        hold_cnt_nxt = cnt_inc;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state_nxt != state) hold_cnt_nxt = '0;

        if (state_nxt == GNT_A && state != GNT_A) last_nxt = 1'b0;
        if (state_nxt == GNT_B && state != GNT_B) last_nxt = 1'b1;

        // sel follows the owner and is left alone while idle.
        if (state_nxt == GNT_A) sel_nxt = 1'b0;
        if (state_nxt == GNT_B) sel_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            last      <= 1'b1;
            sel_q     <= 1'b0;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_cnt_nxt;
            last      <= last_nxt;
            sel_q     <= sel_nxt;
            grant_a_q <= (state_nxt == GNT_A);
            grant_b_q <= (state_nxt == GNT_B);
            valid_q   <= (state_nxt != IDLE);
        end
    end

endmodule
